// File: rtl/video_bus_timing_pkg.sv
// Shared types and constants for the video bus timing generator.
// Holds the bus field layout and the default 800x600 timing constants,
// plus the registered field bundle type.
package video_bus_timing_pkg;

    localparam int BUS_CNT_W      = 11;
    localparam int BUS_RGB_W      = 12;
    localparam int BUS_PCLK_BIT   = 0;
    localparam int BUS_RGB_LSB    = 1;
    localparam int BUS_VBLNK_BIT  = BUS_RGB_LSB + BUS_RGB_W;
    localparam int BUS_HBLNK_BIT  = BUS_VBLNK_BIT + 1;
    localparam int BUS_VSYNC_BIT  = BUS_HBLNK_BIT + 1;
    localparam int BUS_HSYNC_BIT  = BUS_VSYNC_BIT + 1;
    localparam int BUS_VCOUNT_LSB = BUS_HSYNC_BIT + 1;
    localparam int BUS_HCOUNT_LSB = BUS_VCOUNT_LSB + BUS_CNT_W;
    localparam int BUS_W          = BUS_HCOUNT_LSB + BUS_CNT_W - 1;

    localparam int          VT_H_ACTIVE  = 800;
    localparam int          VT_H_FP      = 40;
    localparam int          VT_H_SYNC    = 128;
    localparam int          VT_H_BP      = 88;
    localparam int          VT_V_ACTIVE  = 600;
    localparam int          VT_V_FP      = 1;
    localparam int          VT_V_SYNC    = 4;
    localparam int          VT_V_BP      = 23;
    localparam logic        VT_HSYNC_POL = 1'b1;
    localparam logic        VT_VSYNC_POL = 1'b1;
    localparam logic [11:0] VT_BG_RGB    = 12'h000;

    // Every registered bus field, updated together so none can drift.
    typedef struct packed {
        logic [BUS_CNT_W-1:0] hcount;
        logic [BUS_CNT_W-1:0] vcount;
        logic                 hsync;
        logic                 vsync;
        logic                 hblnk;
        logic                 vblnk;
        logic [BUS_RGB_W-1:0] rgb;
    } bus_fields_t;

    // Drive the sync pin to its active level inside the pulse window.
    function automatic logic sync_level(input logic in_pulse, input logic pol);
        return in_pulse ? pol : ~pol;
    endfunction

    // Field values held while reset is asserted: syncs idle, no blanking.
    function automatic bus_fields_t fields_reset(input logic hpol, input logic vpol);
        bus_fields_t f;
        f        = '0;
        f.hsync  = ~hpol;
        f.vsync  = ~vpol;
        return f;
    endfunction

endpackage

// File: rtl/video_bus_timing_sync_decode.sv
// Combinational blank/sync decode for one video axis.
// Ports:
//   i_cnt   : counter value for this axis
//   o_blnk  : high when i_cnt is outside the active region
//   o_sync  : POL inside [ACTIVE+FP, ACTIVE+FP+SYNC), ~POL elsewhere
module video_bus_timing_sync_decode
    import video_bus_timing_pkg::*;
#(
    parameter int   CNT_WIDTH = 11,
    parameter int   ACTIVE    = 800,
    parameter int   FP        = 40,
    parameter int   SYNC      = 128,
    parameter logic POL       = 1'b1
) (
    input  logic [CNT_WIDTH-1:0] i_cnt,
    output logic                 o_blnk,
    output logic                 o_sync
);

    // One extra bit so the sync end bound cannot wrap when the back porch
    // is zero and the total equals 2**CNT_WIDTH.
    localparam logic [CNT_WIDTH:0] ACTIVE_END = (CNT_WIDTH+1)'(ACTIVE);
    localparam logic [CNT_WIDTH:0] SYNC_START = (CNT_WIDTH+1)'(ACTIVE + FP);
    localparam logic [CNT_WIDTH:0] SYNC_END   = (CNT_WIDTH+1)'(ACTIVE + FP + SYNC);

    logic [CNT_WIDTH:0] w_cnt;
    logic               w_in_pulse;

    assign w_cnt      = {1'b0, i_cnt};
    assign o_blnk     = (w_cnt >= ACTIVE_END);
    assign w_in_pulse = (w_cnt >= SYNC_START) && (w_cnt < SYNC_END);
    assign o_sync     = sync_level(w_in_pulse, POL);

endmodule

// File: rtl/video_bus_timing.sv
// Source end of the video bus: pixel counters, sync/blank decode and the
// background colour, packed onto video_bus_out for the downstream stages.
// Ports:
//   clk           : pixel clock, also forwarded unregistered on the pclk bit
//   rst_n         : asynchronous active-low reset
//   en            : count enable; low freezes counters and all outputs
//   video_bus_out : packed bus (hcount, vcount, syncs, blanks, rgb, pclk)
//   frame_start   : high while the bus presents pixel (0,0)
//   line_start    : high while the bus presents hcount = 0
// All registered fields come from the same counter value one cycle late,
// so they stay mutually aligned.
module video_bus_timing
    import video_bus_timing_pkg::*;
#(
    parameter int          H_ACTIVE  = VT_H_ACTIVE,
    parameter int          H_FP      = VT_H_FP,
    parameter int          H_SYNC    = VT_H_SYNC,
    parameter int          H_BP      = VT_H_BP,
    parameter int          V_ACTIVE  = VT_V_ACTIVE,
    parameter int          V_FP      = VT_V_FP,
    parameter int          V_SYNC    = VT_V_SYNC,
    parameter int          V_BP      = VT_V_BP,
    parameter logic        HSYNC_POL = VT_HSYNC_POL,
    parameter logic        VSYNC_POL = VT_VSYNC_POL,
    parameter logic [11:0] BG_RGB    = VT_BG_RGB,
    parameter int          CNT_WIDTH = BUS_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [BUS_W:0]   video_bus_out,
    output logic             frame_start,
    output logic             line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_WIDTH-1:0] H_LAST = CNT_WIDTH'(H_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] V_LAST = CNT_WIDTH'(V_TOTAL - 1);

    // Elaboration-time guards on the parameter set.
    if (H_TOTAL > 2**CNT_WIDTH) begin : g_h_total_check
        $error("video_bus_timing: H_TOTAL does not fit in CNT_WIDTH bits");
    end
    if (V_TOTAL > 2**CNT_WIDTH) begin : g_v_total_check
        $error("video_bus_timing: V_TOTAL does not fit in CNT_WIDTH bits");
    end
    if (CNT_WIDTH != BUS_CNT_W) begin : g_cnt_width_check
        $error("video_bus_timing: CNT_WIDTH must match the bus count field width");
    end

    logic [CNT_WIDTH-1:0] r_h_cnt;
    logic [CNT_WIDTH-1:0] r_v_cnt;
    logic [CNT_WIDTH-1:0] w_h_cnt_next;
    logic [CNT_WIDTH-1:0] w_v_cnt_next;
    logic                 w_h_last;
    logic                 w_v_last;

    logic                 w_hblnk;
    logic                 w_hsync;
    logic                 w_vblnk;
    logic                 w_vsync;

    bus_fields_t          r_fields;
    logic                 r_frame_start;
    logic                 r_line_start;

    // Next-state for the raster counters: the vertical counter only moves on
    // the cycle the horizontal counter wraps.
    always_comb begin
        w_h_last     = (r_h_cnt == H_LAST);
        w_v_last     = (r_v_cnt == V_LAST);
        w_h_cnt_next = w_h_last ? '0 : r_h_cnt + 1'b1;
        w_v_cnt_next = r_v_cnt;
        if (w_h_last) begin
            w_v_cnt_next = w_v_last ? '0 : r_v_cnt + 1'b1;
        end
    end

    video_bus_timing_sync_decode #(
        .CNT_WIDTH (CNT_WIDTH),
        .ACTIVE    (H_ACTIVE),
        .FP        (H_FP),
        .SYNC      (H_SYNC),
        .POL       (HSYNC_POL)
    ) u_h_decode (
        .i_cnt  (r_h_cnt),
        .o_blnk (w_hblnk),
        .o_sync (w_hsync)
    );

    video_bus_timing_sync_decode #(
        .CNT_WIDTH (CNT_WIDTH),
        .ACTIVE    (V_ACTIVE),
        .FP        (V_FP),
        .SYNC      (V_SYNC),
        .POL       (VSYNC_POL)
    ) u_v_decode (
        .i_cnt  (r_v_cnt),
        .o_blnk (w_vblnk),
        .o_sync (w_vsync)
    );

    // Counters and every output field share one enable so a stalled pipeline
    // sees a perfectly frozen bus, pulses included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_fields      <= fields_reset(HSYNC_POL, VSYNC_POL);
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else if (en) begin
            r_h_cnt         <= w_h_cnt_next;
            r_v_cnt         <= w_v_cnt_next;
            r_fields.hcount <= r_h_cnt;
            r_fields.vcount <= r_v_cnt;
            r_fields.hsync  <= w_hsync;
            r_fields.vsync  <= w_vsync;
            r_fields.hblnk  <= w_hblnk;
            r_fields.vblnk  <= w_vblnk;
            r_fields.rgb    <= (w_hblnk || w_vblnk) ? 12'h000 : BG_RGB;
            r_frame_start   <= (r_h_cnt == '0) && (r_v_cnt == '0);
            r_line_start    <= (r_h_cnt == '0);
        end
    end

    // Bus packing; pclk is the raw clock so downstream stages share it.
    always_comb begin
        video_bus_out                                 = '0;
        video_bus_out[BUS_HCOUNT_LSB +: BUS_CNT_W]    = r_fields.hcount;
        video_bus_out[BUS_VCOUNT_LSB +: BUS_CNT_W]    = r_fields.vcount;
        video_bus_out[BUS_HSYNC_BIT]                  = r_fields.hsync;
        video_bus_out[BUS_VSYNC_BIT]                  = r_fields.vsync;
        video_bus_out[BUS_HBLNK_BIT]                  = r_fields.hblnk;
        video_bus_out[BUS_VBLNK_BIT]                  = r_fields.vblnk;
        video_bus_out[BUS_RGB_LSB +: BUS_RGB_W]       = r_fields.rgb;
        video_bus_out[BUS_PCLK_BIT]                   = clk;
    end

    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;

endmodule

// File: tb/tb_video_bus_timing.sv
`timescale 1ns/1ps
module tb_video_bus_timing;
    import video_bus_timing_pkg::*;

    // Full-size instance (800x600 timing) with a visible background colour.
    localparam logic [11:0] BIG_BG = 12'h3C7;
    // Small instance for whole-frame coverage.
    localparam int SM_HA = 4, SM_HF = 1, SM_HS = 2, SM_HB = 1;
    localparam int SM_VA = 3, SM_VF = 1, SM_VS = 1, SM_VB = 1;
    localparam logic SM_HPOL = 1'b0;
    localparam logic SM_VPOL = 1'b1;
    localparam logic [11:0] SM_BG = 12'hA5C;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        int hpol, vpol, bg;
        int h_total, v_total;
    } timing_t;

    typedef struct {
        int h, v, hsync, vsync, hblnk, vblnk, rgb, fs, ls;
    } pix_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic [BUS_W:0] bus_big, bus_small;
    logic fs_big, ls_big, fs_small, ls_small;

    int n_checks = 0;
    int n_fails  = 0;

    timing_t t_big, t_small;
    pix_t    shown_big, shown_small;
    int      nxt_big, nxt_small;

    always #5 clk = ~clk;

    video_bus_timing #(
        .BG_RGB (BIG_BG)
    ) dut_big (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .video_bus_out (bus_big),
        .frame_start   (fs_big),
        .line_start    (ls_big)
    );

    video_bus_timing #(
        .H_ACTIVE (SM_HA), .H_FP (SM_HF), .H_SYNC (SM_HS), .H_BP (SM_HB),
        .V_ACTIVE (SM_VA), .V_FP (SM_VF), .V_SYNC (SM_VS), .V_BP (SM_VB),
        .HSYNC_POL (SM_HPOL), .VSYNC_POL (SM_VPOL), .BG_RGB (SM_BG)
    ) dut_small (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .video_bus_out (bus_small),
        .frame_start   (fs_small),
        .line_start    (ls_small)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic timing_t make_timing(int ha, int hf, int hs, int hb,
                                            int va, int vf, int vs, int vb,
                                            int hpol, int vpol, int bg);
        timing_t t;
        t.ha = ha; t.hf = hf; t.hs = hs; t.hb = hb;
        t.va = va; t.vf = vf; t.vs = vs; t.vb = vb;
        t.hpol = hpol; t.vpol = vpol; t.bg = bg;
        t.h_total = ha + hf + hs + hb;
        t.v_total = va + vf + vs + vb;
        return t;
    endfunction

    // Expected bus contents for raster position p (pixels since frame start).
    function automatic pix_t pixel_at(timing_t t, int p);
        pix_t r;
        int h, v;
        h = p % t.h_total;
        v = p / t.h_total;
        r.h     = h;
        r.v     = v;
        r.hblnk = (h >= t.ha) ? 1 : 0;
        r.vblnk = (v >= t.va) ? 1 : 0;
        r.hsync = (h >= t.ha + t.hf && h < t.ha + t.hf + t.hs) ? t.hpol : 1 - t.hpol;
        r.vsync = (v >= t.va + t.vf && v < t.va + t.vf + t.vs) ? t.vpol : 1 - t.vpol;
        r.rgb   = (r.hblnk == 1 || r.vblnk == 1) ? 0 : t.bg;
        r.fs    = (p == 0) ? 1 : 0;
        r.ls    = (h == 0) ? 1 : 0;
        return r;
    endfunction

    function automatic pix_t reset_pix(timing_t t);
        pix_t r;
        r.h = 0; r.v = 0; r.hblnk = 0; r.vblnk = 0; r.rgb = 0; r.fs = 0; r.ls = 0;
        r.hsync = 1 - t.hpol;
        r.vsync = 1 - t.vpol;
        return r;
    endfunction

    task automatic model_reset();
        shown_big   = reset_pix(t_big);
        shown_small = reset_pix(t_small);
        nxt_big     = 0;
        nxt_small   = 0;
    endtask

    // Advance the model on an active edge where the DUT is allowed to move.
    task automatic model_step();
        if (rst_n === 1'b1 && en === 1'b1) begin
            shown_big   = pixel_at(t_big, nxt_big);
            nxt_big     = (nxt_big + 1) % (t_big.h_total * t_big.v_total);
            shown_small = pixel_at(t_small, nxt_small);
            nxt_small   = (nxt_small + 1) % (t_small.h_total * t_small.v_total);
        end
    endtask

    task automatic compare_dut(input string nm, input pix_t e, input logic [BUS_W:0] b,
                               input logic fs, input logic ls);
        check_value({nm, "_hcount"}, 32'(b[BUS_HCOUNT_LSB +: BUS_CNT_W]), 32'(e.h));
        check_value({nm, "_vcount"}, 32'(b[BUS_VCOUNT_LSB +: BUS_CNT_W]), 32'(e.v));
        check_value({nm, "_hsync"},  32'(b[BUS_HSYNC_BIT]), 32'(e.hsync));
        check_value({nm, "_vsync"},  32'(b[BUS_VSYNC_BIT]), 32'(e.vsync));
        check_value({nm, "_hblnk"},  32'(b[BUS_HBLNK_BIT]), 32'(e.hblnk));
        check_value({nm, "_vblnk"},  32'(b[BUS_VBLNK_BIT]), 32'(e.vblnk));
        check_value({nm, "_rgb"},    32'(b[BUS_RGB_LSB +: BUS_RGB_W]), 32'(e.rgb));
        check_value({nm, "_frame_start"}, 32'(fs), 32'(e.fs));
        check_value({nm, "_line_start"},  32'(ls), 32'(e.ls));
        check_value({nm, "_pclk"}, 32'(b[BUS_PCLK_BIT]), 32'(clk));
    endtask

    task automatic compare_all();
        compare_dut("big", shown_big, bus_big, fs_big, ls_big);
        compare_dut("small", shown_small, bus_small, fs_small, ls_small);
    endtask

    // One clock: model follows the edge, DUT sampled 1 ns later.
    task automatic step_cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Run enabled until the big instance presents hcount == target.
    task automatic run_until_h(input int target, input int budget);
        int k;
        k = 0;
        en = 1'b1;
        while (shown_big.h != target && k < budget) begin
            step_cycle();
            k++;
        end
        check_value("reach_hcount", 32'(bus_big[BUS_HCOUNT_LSB +: BUS_CNT_W]), 32'(target));
    endtask

    // Reset pulse placed between clock edges; outputs must clear at once.
    task automatic async_reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #3 rst_n = 1'b1;
    endtask

    initial begin
        int cyc, last_fs_small, last_ls_big;

        t_big   = make_timing(800, 40, 128, 88, 600, 1, 4, 23, 1, 1, int'(BIG_BG));
        t_small = make_timing(SM_HA, SM_HF, SM_HS, SM_HB, SM_VA, SM_VF, SM_VS, SM_VB,
                              int'(SM_HPOL), int'(SM_VPOL), int'(SM_BG));
        rst_n = 1'b0;
        en    = 1'b1;
        model_reset();

        // Reset state, with the forwarded clock seen at both levels.
        repeat (3) @(posedge clk);
        #1 compare_all();
        #5 check_value("pclk_low", 32'(bus_big[BUS_PCLK_BIT]), 32'(0));
        rst_n = 1'b1;

        // Continuous run: line wrap on the big instance, many small frames.
        last_fs_small = -1;
        last_ls_big   = -1;
        for (cyc = 1; cyc <= 1100; cyc++) begin
            step_cycle();
            if (fs_small === 1'b1) begin
                if (last_fs_small >= 0)
                    check_value("small_frame_period", 32'(cyc - last_fs_small), 32'(48));
                last_fs_small = cyc;
            end
            if (ls_big === 1'b1) begin
                if (last_ls_big >= 0)
                    check_value("big_line_period", 32'(cyc - last_ls_big), 32'(1056));
                last_ls_big = cyc;
            end
        end

        // Stall for 10 cycles at hcount 500, then resume at 501.
        run_until_h(500, 1200);
        en = 1'b0;
        repeat (10) step_cycle();
        en = 1'b1;
        step_cycle();
        check_value("resume_hcount", 32'(bus_big[BUS_HCOUNT_LSB +: BUS_CNT_W]), 32'(501));

        // Mid-line asynchronous reset, then restart from (0,0).
        run_until_h(900, 1200);
        async_reset_pulse();
        step_cycle();
        check_value("restart_frame_start", 32'(fs_big), 32'(1));

        // Random enable with occasional reset pulses.
        for (int i = 0; i < 6000; i++) begin
            en = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 799) == 0) async_reset_pulse();
            step_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/video_bus_timing.md
Name: video_bus_timing

Overview:
- Source end of the video bus: generates the pixel-timing counters, sync and blanking, and packs them onto `BUS_WIDTH video_bus_out with a background colour.
- Every downstream draw stage (rect, image, text overlays) consumes this bus in series.
- The final stage converts the bus to VGA pins.
- Default timing is 800x600@60 Hz at a 40 MHz pixel clock.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch
- H_SYNC, 128, hsync width
- H_BP, 88, horizontal back porch
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch
- V_SYNC, 4, vsync width
- V_BP, 23, vertical back porch
- HSYNC_POL, 1, active level of hsync
- VSYNC_POL, 1, active level of vsync
- BG_RGB, 12'h0_0_0, rgb driven during active video
- CNT_WIDTH, 11, hcount/vcount field width; must match video_bus.h

Ports:
- clk  input  1  pixel clock; also forwarded on bus bit `BUS_PCLK
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  count enable; when low the counters and outputs hold
- video_bus_out  output  `BUS_WIDTH+1  packed bus: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb, pclk, using the field macros in video_bus.h
- frame_start  output  1  one-cycle pulse when the bus presents (0,0)
- line_start  output  1  one-cycle pulse when the bus presents hcount=0

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).
- Internal counters h_cnt and v_cnt:
  - When en=1, h_cnt increments each clk.
  - When h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - When v_cnt = V_TOTAL-1 and h_cnt wraps, v_cnt wraps to 0.
  - When en=0, both counters hold.
- All bus fields except pclk are registered from the same counter value, one cycle after that value. hcount, vcount, syncs, blanks, rgb, frame_start and line_start are therefore always mutually aligned. No field may lead or lag another.
- Field decode:
  - hblnk = (h >= H_ACTIVE)
  - hsync = HSYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, otherwise ~HSYNC_POL
  - vblnk and vsync decode v the same way, using the V_* parameters
  - rgb = BG_RGB when neither hblnk nor vblnk is set, otherwise 12'h000
- pclk bit = clk, driven combinationally with no register.
- frame_start = 1 exactly when the registered hcount=0 and vcount=0. line_start = 1 when the registered hcount=0.
- Reset (rst_n=0, asynchronous):
  - h_cnt = 0, v_cnt = 0
  - registered hcount = 0, vcount = 0, hblnk = 0, vblnk = 0
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
  - rgb = 12'h000, frame_start = 0, line_start = 0
- First edge after rst_n rises (with en=1):
  - The bus shows (0,0) with frame_start = line_start = 1.
  - rgb = BG_RGB.
  - Internal counters advance to (1,0).
- Reset asserted mid-frame: immediate return to reset values. No partial-line completion.
- en deasserted: all outputs freeze at their current values, including pulses. A pulse that was high stays high until the next enabled edge.
- Boundaries:
  - hcount spans 0..H_TOTAL-1 and never reaches H_TOTAL.
  - vcount spans 0..V_TOTAL-1.
  - vcount changes in the same cycle that hcount shows 0.
- Arithmetic: all comparisons are unsigned at CNT_WIDTH bits. Parameter sums must fit CNT_WIDTH; a synthesis-time check errors if H_TOTAL or V_TOTAL exceeds 2**CNT_WIDTH.

Decomposition:
- video_bus.h keeps BUS_WIDTH and the field bit macros (BUS_PCLK, BUS_HCOUNT, BUS_VCOUNT, BUS_HSYNC, BUS_VSYNC, BUS_HBLNK, BUS_VBLNK, BUS_RGB). The generator writes only through these macros.
- Add a shared timing-constants include, video_timing.h, holding the 800x600 defaults. Parameters default from it.
- One sub-module is natural: sync_decode.
  - Purely combinational: takes a counter value plus ACTIVE/FP/SYNC/POL and returns blnk and sync.
  - Instantiated twice, once horizontal and once vertical.

Test Plan:
- Reset and release, en=1: during reset the bus shows hcount=0, vcount=0, hsync=vsync=0 (POL=1). First edge after release: hcount=0, frame_start=1, rgb=BG_RGB.
- Run one line: hblnk rises at hcount=800. hsync is 1 for hcount 840..967 and 0 at 968. At hcount=1055, the next cycle shows hcount=0, vcount=1, line_start=1.
- Run one full frame (663168 cycles): vblnk is set for vcount 600..627. vsync is high for vcount 601..604 only. frame_start pulses exactly once per 663168 cycles. vcount never shows 628.
- en held low for 10 cycles at hcount=500: all bus fields are constant. Resume at hcount=501 with no skipped value.
- rst_n pulsed low asynchronously (not clock-aligned) at hcount=900, vcount=300: outputs return to reset values within the pulse, without waiting for clk. The restart begins at (0,0).
- Small parameters: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, HSYNC_POL=0, with the bus compared against a cycle-accurate model.
  - Required: 48-cycle frame period.
  - Required: hsync=0 at hcount 5..6.
  - Required: rgb=0 whenever blanked.
